regfile_wr_arbiter: RTL
=======================

Name: regfile_wr_arbiter

Overview:
- Owns the single register-file write port (WE3/A3/WD3) and shares it between two writeback requesters: req0 (single-cycle ALU/load writeback) and req1 (multi-cycle unit writeback).
- Uses round-robin arbitration with a valid/ready handshake.
- Suppresses writes to register 0 so $zero stays architecturally zero.
- Provides a clear sequencer that zeroes every register through the write port on command.

Parameters:
- RegAdd_WIDTH, 5: register address width.
- RegFile_WIDTH, 32: register data width.
- RegFile_DEPTH, 32: number of registers cleared by the sequencer; equals 2**RegAdd_WIDTH.

Ports:
- CLK  input  1  clock; all state updates on its rising edge.
- RST  input  1  reset; synchronous, active-high.
- req0_valid  input  1  requester 0 has a write pending.
- req0_addr  input  RegAdd_WIDTH  requester 0 destination register.
- req0_data  input  RegFile_WIDTH  requester 0 write data.
- req0_ready  output  1  requester 0 write accepted this cycle (combinational).
- req1_valid  input  1  requester 1 has a write pending.
- req1_addr  input  RegAdd_WIDTH  requester 1 destination register.
- req1_data  input  RegFile_WIDTH  requester 1 write data.
- req1_ready  output  1  requester 1 write accepted this cycle (combinational).
- clr_start  input  1  request a full register-file clear.
- clr_busy  output  1  clear sequence in progress (registered).
- clr_done  output  1  one-cycle pulse when the clear completes (registered).
- WE3  output  1  register-file write enable (registered).
- A3  output  RegAdd_WIDTH  register-file write address (registered).
- WD3  output  RegFile_WIDTH  register-file write data (registered).

Behaviour:
- Reset values (RST=1 at a rising edge): state=IDLE, WE3=0, A3=0, WD3=0, clr_busy=0, clr_done=0, clear counter=0, last_grant=1 (req0 wins the first conflict).
- States: IDLE (arbitrating) and CLEAR.
- Transfer rule: a transfer occurs when reqN_valid & reqN_ready.
  - At most one ready is high in any cycle.
  - ready is never high without the matching valid.
- Readiness in IDLE:
  - Both readies are 0 while clr_start=1 (clear has priority).
  - Only one valid: that requester is ready.
  - Both valid: grant the requester != last_grant.
  - last_grant updates to the granted index on every transfer.
- Readiness in CLEAR: both readies are 0.
- Write latency: a transfer at edge T drives WE3=1, A3=addr, WD3=data during cycle T+1.
  - WE3 returns to 0 the following cycle unless another write is issued.
  - Maximum throughput is one write per cycle.
- Register 0 suppression:
  - A transfer with addr=0 completes the handshake and updates last_grant.
  - WE3 stays 0 for it; A3 and WD3 hold their previous values.
- Idle write port: WE3=0; A3 and WD3 hold their last values.
- Clear entry: clr_start=1 in IDLE at edge T moves to CLEAR, clr_busy=1 and counter=0 from T+1.
- Clear sequence:
  - In CLEAR, one write per cycle: WE3=1, A3=counter, WD3=0 during cycles T+1..T+RegFile_DEPTH, so A3 steps 0..RegFile_DEPTH-1.
  - Register 0 is included in the clear.
  - The counter increments each cycle.
- Clear exit:
  - After the write with A3=RegFile_DEPTH-1, the block returns to IDLE at T+RegFile_DEPTH+1.
  - In that cycle clr_busy=0, clr_done=1 (one cycle only), and WE3=0.
- Post-clear acceptance: the first request can be accepted in cycle T+RegFile_DEPTH+1, with its write landing at T+RegFile_DEPTH+2.
- clr_start while in CLEAR is ignored; it does not extend or restart the sequence.
- Simultaneous clr_start and valid requests in IDLE: the clear wins, no transfer occurs, and the requests stay pending.
- Reset mid-clear:
  - Returns to IDLE with all reset values next cycle.
  - No clr_done pulse.
  - Partially cleared registers are not re-cleared.
- No internal buffering: the requester holds valid/addr/data stable until it sees ready.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, release -> WE3=0, A3=0, WD3=0, clr_busy=0, clr_done=0, both readies 0 with no valids.
- Single requester: req0 valid addr=5 data=0xDEADBEEF at edge T -> req0_ready=1 in that cycle; WE3=1, A3=5, WD3=0xDEADBEEF in cycle T+1; WE3=0 at T+2.
- Contention round-robin:
  - Stimulus: after reset, req0 (addr=3, 0x11) and req1 (addr=4, 0x22) held valid.
  - Response: grants in order req0, req1; writes A3=3/0x11 then A3=4/0x22 on consecutive cycles; never both readies high.
  - Continuing with new data each cycle gives grants strictly alternating 0,1,0,1.
- $zero suppression: req1 valid addr=0 data=0xFFFFFFFF -> req1_ready=1, WE3 stays 0, A3/WD3 unchanged; a following req0 conflict is granted to req0.
- Clear sequence:
  - Stimulus: clr_start pulse at T with req0 also valid.
  - Response: req0_ready=0; WE3=1, WD3=0, A3=0..31 over cycles T+1..T+32, with clr_busy=1 throughout.
  - Cycle T+33: clr_done=1 for exactly one cycle, and req0 is accepted.
  - A second clr_start at T+10 has no effect.
- Reset mid-clear: RST=1 at T+15 -> next cycle IDLE, WE3=0, clr_busy=0, no clr_done pulse; new requests are accepted normally after RST=0.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - register-file write-port arbiter with round-robin grant and clear sequencer
module regfile_wr_arbiter #(
    parameter int RegAdd_WIDTH  = 5,
    parameter int RegFile_WIDTH = 32,
    parameter int RegFile_DEPTH = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     req0_valid,
    input  logic [RegAdd_WIDTH-1:0]  req0_addr,
    input  logic [RegFile_WIDTH-1:0] req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [RegAdd_WIDTH-1:0]  req1_addr,
    input  logic [RegFile_WIDTH-1:0] req1_data,
    output logic                     req1_ready,
    input  logic                     clr_start,
    output logic                     clr_busy,
    output logic                     clr_done,
    output logic                     WE3,
    output logic [RegAdd_WIDTH-1:0]  A3,
    output logic [RegFile_WIDTH-1:0] WD3
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [RegAdd_WIDTH-1:0] LastAddr = RegAdd_WIDTH'(RegFile_DEPTH - 1);

    state_t                   state_q, state_d;
    logic                     last_grant_q, last_grant_d;
    logic [RegAdd_WIDTH-1:0]  cnt_q, cnt_d;
    logic                     we_q, we_d;
    logic [RegAdd_WIDTH-1:0]  addr_q, addr_d;
    logic [RegFile_WIDTH-1:0] data_q, data_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     grant0, grant1;

    // A lone valid is always granted; on conflict the requester not granted last wins.
    assign grant0 = req0_valid && (!req1_valid || last_grant_q);
    assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    // The first clear write (address 0) is issued on the entry edge itself.
                    state_d = CLEAR;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    we_d    = 1'b1;
                    addr_d  = '0;
                    data_d  = '0;
                end else if (grant0) begin
                    req0_ready   = 1'b1;
                    last_grant_d = 1'b0;
                    if (req0_addr != '0) begin
                        we_d   = 1'b1;
                        addr_d = req0_addr;
                        data_d = req0_data;
                    end
                end else if (grant1) begin
                    req1_ready   = 1'b1;
                    last_grant_d = 1'b1;
                    if (req1_addr != '0) begin
                        we_d   = 1'b1;
                        addr_d = req1_addr;
                        data_d = req1_data;
                    end
                end
            end
            CLEAR: begin
                if (cnt_q == LastAddr) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    we_d   = 1'b1;
                    addr_d = cnt_q + 1'b1;
                    data_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign WE3      = we_q;
    assign A3       = addr_q;
    assign WD3      = data_q;
    assign clr_busy = busy_q;
    assign clr_done = done_q;

endmodule
